// File: rtl/if_stage.sv
// RV32I instruction fetch stage: owns the fetch PC, drives the req/ack instruction port,
// and holds the IF/ID register with a one-entry skid for decoder stalls.
module if_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] iport_addr,
    output logic        iport_req,
    input  logic        iport_ack,
    input  logic [31:0] iport_data,
    input  logic        iport_err,
    input  logic        id_stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        if_valid,
    output logic        fetch_misaligned,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_HOLD, S_DISCARD, S_HALT} state_t;
    typedef enum logic [1:0] {IFID_KEEP, IFID_BUBBLE, IFID_MEM, IFID_SKID} ifid_op_t;

    state_t      state_q, state_d;
    ifid_op_t    ifid_op;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] discard_addr_q, discard_addr_d;
    logic [31:0] skid_pc_q, skid_instr_q;
    logic        skid_load;
    logic        misaligned_d, fault_d;
    logic        target_misaligned;

    // A killed request keeps presenting its original address until the memory answers,
    // while fetch_pc already holds the redirect target.
    assign iport_req         = (state_q == S_FETCH) || (state_q == S_DISCARD);
    assign iport_addr        = (state_q == S_DISCARD) ? discard_addr_q : fetch_pc_q;
    assign target_misaligned = (branch_target[1:0] != 2'b00);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned
        // and no latch is inferred.
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        discard_addr_d = discard_addr_q;
        skid_load      = 1'b0;
        ifid_op        = IFID_KEEP;
        misaligned_d   = fetch_misaligned;
        fault_d        = fetch_fault;

        if (branch_taken) begin
            ifid_op      = IFID_BUBBLE;
            fetch_pc_d   = branch_target;
            misaligned_d = target_misaligned;
            if (!target_misaligned) fault_d = 1'b0;
            if (state_q == S_FETCH && !iport_ack) begin
                state_d        = S_DISCARD;
                discard_addr_d = fetch_pc_q;
            end else if (state_q == S_DISCARD && !iport_ack) begin
                state_d = S_DISCARD;
            end else begin
                state_d = target_misaligned ? S_HALT : S_FETCH;
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_FETCH;
                S_FETCH: begin
                    if (iport_ack) begin
                        if (iport_err) begin
                            fault_d = 1'b1;
                            ifid_op = IFID_BUBBLE;
                            state_d = S_HALT;
                        end else if (id_stall) begin
                            skid_load  = 1'b1;
                            fetch_pc_d = fetch_pc_q + 32'd4;
                            state_d    = S_HOLD;
                        end else begin
                            ifid_op    = IFID_MEM;
                            fetch_pc_d = fetch_pc_q + 32'd4;
                        end
                    end else if (!id_stall) begin
                        ifid_op = IFID_BUBBLE;
                    end
                end
                S_HOLD: begin
                    if (!id_stall) begin
                        ifid_op = IFID_SKID;
                        state_d = S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (!id_stall) ifid_op = IFID_BUBBLE;
                    // A misaligned redirect that arrived mid-request parks in HALT once the
                    // stale response has drained.
                    if (iport_ack) state_d = fetch_misaligned ? S_HALT : S_FETCH;
                end
                S_HALT:  ifid_op = IFID_BUBBLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            fetch_pc_q       <= RESET_ADDR;
            discard_addr_q   <= RESET_ADDR;
            skid_pc_q        <= '0;
            skid_instr_q     <= NOP_INSTR;
            pc               <= '0;
            instruction      <= NOP_INSTR;
            if_valid         <= 1'b0;
            fetch_misaligned <= 1'b0;
            fetch_fault      <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q          <= state_d;
            fetch_pc_q       <= fetch_pc_d;
            discard_addr_q   <= discard_addr_d;
            fetch_misaligned <= misaligned_d;
            fetch_fault      <= fault_d;

            if (skid_load) begin
                skid_pc_q    <= fetch_pc_q;
                skid_instr_q <= iport_data;
            end else if (branch_taken) begin
                skid_instr_q <= NOP_INSTR;
            end

            case (ifid_op)
                IFID_BUBBLE: begin
                    instruction <= NOP_INSTR;
                    if_valid    <= 1'b0;
                end
                IFID_MEM: begin
                    pc          <= fetch_pc_q;
                    instruction <= iport_data;
                    if_valid    <= 1'b1;
                end
                IFID_SKID: begin
                    pc          <= skid_pc_q;
                    instruction <= skid_instr_q;
                    if_valid    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run checked against an
// instruction-stream model (decode must see consecutive words from the last redirect).
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] iport_addr;
    logic        iport_req;
    logic        iport_ack;
    logic [31:0] iport_data;
    logic        iport_err;
    logic        id_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        if_valid;
    logic        fetch_misaligned;
    logic        fetch_fault;

    if_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .iport_addr       (iport_addr),
        .iport_req        (iport_req),
        .iport_ack        (iport_ack),
        .iport_data       (iport_data),
        .iport_err        (iport_err),
        .id_stall         (id_stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .pc               (pc),
        .instruction      (instruction),
        .if_valid         (if_valid),
        .fetch_misaligned (fetch_misaligned),
        .fetch_fault      (fetch_fault)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;

    // Memory model: lat_mode 0..2 is a fixed wait count, 3 picks one per request.
    int unsigned lat_mode = 0;
    bit          busy = 1'b0;
    int unsigned wait_left = 0;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = '0;

    // Stream model: address decode is expected to consume next.
    logic [31:0] exp_pc = '0;
    int unsigned consumed = 0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'd1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mem_drive();
        if (!iport_req) begin
            busy       = 1'b0;
            iport_ack  = 1'b0;
            iport_data = $urandom;
            iport_err  = 1'($urandom_range(0, 1));
        end else begin
            if (!busy) begin
                busy      = 1'b1;
                wait_left = (lat_mode > 2) ? $urandom_range(0, 2) : lat_mode;
            end
            if (wait_left == 0) begin
                iport_ack  = 1'b1;
                iport_data = mem_word(iport_addr);
                iport_err  = err_en && (iport_addr == err_addr);
                busy       = 1'b0;
            end else begin
                iport_ack  = 1'b0;
                iport_data = $urandom;
                iport_err  = 1'($urandom_range(0, 1));
                wait_left--;
            end
        end
    endtask

    // Called at a falling edge with id_stall/branch_* already set for the coming edge.
    task automatic tick();
        mem_drive();
        if (if_valid && !id_stall && !branch_taken) begin
            check("stream_pc", pc, exp_pc);
            check("stream_instr", instruction, mem_word(exp_pc));
            exp_pc += 32'd4;
            consumed++;
        end
        if (branch_taken) exp_pc = branch_target;
        prev_hold = iport_req && !iport_ack;
        prev_addr = iport_addr;
        @(posedge clk);
        @(negedge clk);
        if (prev_hold) begin
            check("hs_req_held", iport_req, 1);
            check("hs_addr_stable", iport_addr, prev_addr);
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        branch_taken  = 1'b1;
        branch_target = target;
        tick();
        branch_taken  = 1'b0;
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        iport_ack     = 1'b0;
        iport_data    = '0;
        iport_err     = 1'b0;
        id_stall      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        repeat (2) @(negedge clk);

        check("rst_req", iport_req, 0);
        check("rst_addr", iport_addr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instruction, NOP);
        check("rst_valid", if_valid, 0);
        check("rst_misaligned", fetch_misaligned, 0);
        check("rst_fault", fetch_fault, 0);

        // Zero-wait memory: one instruction per cycle from the reset address.
        rst_n = 1'b1;
        tick();
        check("first_req", iport_req, 1);
        check("first_addr", iport_addr, 32'h0);
        check("first_valid", if_valid, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("seq_pc", pc, 32'(4 * k));
            check("seq_instr", instruction, 32'(4 * k + 1));
            check("seq_valid", if_valid, 1);
        end

        // Reset while a request is outstanding.
        check("pre_rst_req", iport_req, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_req", iport_req, 0);
        check("async_rst_valid", if_valid, 0);
        check("async_rst_addr", iport_addr, 32'h0);
        exp_pc    = '0;
        busy      = 1'b0;
        iport_ack = 1'b0;
        prev_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rerst_req", iport_req, 1);
        check("rerst_addr", iport_addr, 32'h0);

        // Decoder stall across the fetch of 0x8.
        tick();
        check("st_pc0", pc, 32'h0);
        tick();
        check("st_pc4", pc, 32'h4);
        id_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("st_hold_pc", pc, 32'h4);
            check("st_hold_valid", if_valid, 1);
        end
        check("st_hold_req", iport_req, 0);
        id_stall = 1'b0;
        tick();
        check("st_rel_pc", pc, 32'h8);
        check("st_rel_instr", instruction, 32'h9);
        tick();
        check("st_next_pc", pc, 32'hC);
        check("st_next_instr", instruction, 32'hD);

        // Two-cycle memory, redirect while the 0x10 fetch is in flight.
        lat_mode = 2;
        check("kill_req_addr", iport_addr, 32'h10);
        tick();
        check("kill_bubble", if_valid, 0);
        redirect(32'h100);
        check("kill_old_addr", iport_addr, 32'h10);
        check("kill_valid", if_valid, 0);
        tick();
        check("kill_new_req", iport_req, 1);
        check("kill_new_addr", iport_addr, 32'h100);
        check("kill_new_valid", if_valid, 0);
        n = 0;
        while (!if_valid && n < 8) begin
            tick();
            n++;
        end
        check("kill_tgt_valid", if_valid, 1);
        check("kill_tgt_pc", pc, 32'h100);
        check("kill_tgt_instr", instruction, 32'h101);

        // Misaligned redirect halts fetch until an aligned one.
        lat_mode = 0;
        redirect(32'h102);
        check("mis_flag", fetch_misaligned, 1);
        check("mis_req", iport_req, 0);
        check("mis_valid", if_valid, 0);
        repeat (2) begin
            tick();
            check("mis_halt_req", iport_req, 0);
            check("mis_halt_flag", fetch_misaligned, 1);
        end
        redirect(32'h200);
        check("mis_clr", fetch_misaligned, 0);
        check("mis_clr_req", iport_req, 1);
        check("mis_clr_addr", iport_addr, 32'h200);
        tick();
        check("mis_tgt_pc", pc, 32'h200);
        check("mis_tgt_instr", instruction, 32'h201);

        // Bus error on the fetch of 0x20.
        err_en   = 1'b1;
        err_addr = 32'h20;
        redirect(32'h18);
        tick();
        check("err_pc18", pc, 32'h18);
        tick();
        check("err_pc1c", pc, 32'h1C);
        tick();
        check("err_fault", fetch_fault, 1);
        check("err_valid", if_valid, 0);
        check("err_req", iport_req, 0);
        check("err_mis", fetch_misaligned, 0);
        repeat (3) begin
            tick();
            check("err_halt_req", iport_req, 0);
            check("err_halt_fault", fetch_fault, 1);
        end
        redirect(32'h40);
        err_en = 1'b0;
        check("err_clr", fetch_fault, 0);
        check("err_clr_req", iport_req, 1);
        check("err_clr_addr", iport_addr, 32'h40);

        // Fetch PC wraps past the top of the address space.
        redirect(32'hFFFF_FFF8);
        tick();
        check("wrap_pc0", pc, 32'hFFFF_FFF8);
        tick();
        check("wrap_pc1", pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc2", pc, 32'h0);
        check("wrap_instr2", instruction, 32'h1);

        // Randomized latency, stalls and aligned redirects against the stream model.
        lat_mode = 3;
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            id_stall     = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0)
                branch_target = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
            else
                branch_target = 32'($urandom_range(0, 1023)) << 2;
            tick();
        end
        id_stall     = 1'b0;
        branch_taken = 1'b0;
        repeat (8) tick();
        check("rand_progress", 32'(consumed > 300), 1);
        check("rand_no_fault", fetch_fault, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
